div_iter: RTL and testbench

- Hand-written iterative radix-2 restoring divider; it is the responder end of the divider stream handshake that the EX stage drives.
- Replaces the vendor div_signed / div_unsigned IP with identical channel semantics, so EX instantiates it once per signedness via the SIGNED parameter.
- Accepts dividend and divisor on independent valid/ready channels, iterates one quotient bit per cycle, and returns {quotient, remainder} on a single output channel.
- Adds a cancel input so a later exception flush can abort an in-flight division.

---
 rtl/div_iter.sv | 140 ++++++++++++++
 tb/tb_div_iter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (one quotient bit per cycle), signed or unsigned via SIGNED.
// Latency: result strobe W+1 cycles after the second operand is accepted; output has no backpressure.
module div_iter #(
    parameter int W      = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cancel,
    input  logic [W-1:0]     s_axis_dividend_tdata,
    input  logic             s_axis_dividend_tvalid,
    output logic             s_axis_dividend_tready,
    input  logic [W-1:0]     s_axis_divisor_tdata,
    input  logic             s_axis_divisor_tvalid,
    output logic             s_axis_divisor_tready,
    output logic [2*W-1:0]   m_axis_dout_tdata,
    output logic             m_axis_dout_tvalid
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_dvd_cap;
    logic           r_dvs_cap;
    logic [W-1:0]   r_dvd_raw;
    logic [W-1:0]   r_dvs_raw;
    logic [W-1:0]   r_quo;
    logic [W-1:0]   r_dvs;
    logic [W-1:0]   r_rem;
    logic           r_neg_q;
    logic           r_neg_r;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_dout;

    logic           w_dvd_xfer;
    logic           w_dvs_xfer;
    logic           w_both;
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_abs;
    logic [W-1:0]   w_b_abs;
    logic [W:0]     w_shift;
    logic [W:0]     w_diff;
    logic           w_qbit;
    logic [W-1:0]   w_rem_nxt;
    logic [W-1:0]   w_quo_nxt;
    logic [W-1:0]   w_quo_fix;
    logic [W-1:0]   w_rem_fix;

    // A transfer coinciding with cancel is dropped.
    assign w_dvd_xfer = (r_state == IDLE) && s_axis_dividend_tvalid && !r_dvd_cap && !cancel;
    assign w_dvs_xfer = (r_state == IDLE) && s_axis_divisor_tvalid  && !r_dvs_cap && !cancel;
    assign w_both     = (r_dvd_cap || w_dvd_xfer) && (r_dvs_cap || w_dvs_xfer);

    assign w_a     = w_dvd_xfer ? s_axis_dividend_tdata : r_dvd_raw;
    assign w_b     = w_dvs_xfer ? s_axis_divisor_tdata  : r_dvs_raw;
    assign w_a_neg = SIGNED && w_a[W-1];
    assign w_b_neg = SIGNED && w_b[W-1];
    assign w_a_abs = w_a_neg ? -w_a : w_a;
    assign w_b_abs = w_b_neg ? -w_b : w_b;

    // Partial remainder stays below the divisor, so a set bit W in the difference means borrow.
    assign w_shift   = {r_rem, r_quo[W-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = !w_diff[W];
    assign w_rem_nxt = w_qbit ? w_diff[W-1:0] : w_shift[W-1:0];
    assign w_quo_nxt = {r_quo[W-2:0], w_qbit};
    assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_both) w_state_nxt = CALC;
            CALC:    if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (cancel) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_dvd_cap <= 1'b0;
            r_dvs_cap <= 1'b0;
            r_cnt     <= '0;
            r_dout    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (cancel) begin
                r_dvd_cap <= 1'b0;
                r_dvs_cap <= 1'b0;
                r_cnt     <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_dvd_xfer) begin
                            r_dvd_cap <= 1'b1;
                            r_dvd_raw <= s_axis_dividend_tdata;
                        end
                        if (w_dvs_xfer) begin
                            r_dvs_cap <= 1'b1;
                            r_dvs_raw <= s_axis_divisor_tdata;
                        end
                        if (w_both) begin
                            r_quo   <= w_a_abs;
                            r_dvs   <= w_b_abs;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_cnt   <= CW'(W - 1);
                        end
                    end
                    CALC: begin
                        r_quo <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == '0) r_dout <= {w_quo_fix, w_rem_fix};
                    end
                    DONE: begin
                        r_dvd_cap <= 1'b0;
                        r_dvs_cap <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_axis_dividend_tready = (r_state == IDLE) && !r_dvd_cap;
    assign s_axis_divisor_tready  = (r_state == IDLE) && !r_dvs_cap;
    assign m_axis_dout_tvalid     = (r_state == DONE);
    assign m_axis_dout_tdata      = r_dout;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: one unsigned and one signed instance, directed vectors.
module tb_div_iter;
    typedef struct {
        logic [63:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        u_cancel, s_cancel;
    logic [31:0] u_dvd_dat, u_dvs_dat, s_dvd_dat, s_dvs_dat;
    logic        u_dvd_vld, u_dvs_vld, s_dvd_vld, s_dvs_vld;
    logic        u_dvd_rdy, u_dvs_rdy, s_dvd_rdy, s_dvs_rdy;
    logic [63:0] u_out_dat, s_out_dat;
    logic        u_out_vld, s_out_vld;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t uq[$];
    exp_t sq[$];
    exp_t ue, se;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    div_iter #(.W(32), .SIGNED(1'b0)) u_dut (
        .clk(clk), .reset(reset), .cancel(u_cancel),
        .s_axis_dividend_tdata(u_dvd_dat), .s_axis_dividend_tvalid(u_dvd_vld),
        .s_axis_dividend_tready(u_dvd_rdy),
        .s_axis_divisor_tdata(u_dvs_dat), .s_axis_divisor_tvalid(u_dvs_vld),
        .s_axis_divisor_tready(u_dvs_rdy),
        .m_axis_dout_tdata(u_out_dat), .m_axis_dout_tvalid(u_out_vld)
    );

    div_iter #(.W(32), .SIGNED(1'b1)) s_dut (
        .clk(clk), .reset(reset), .cancel(s_cancel),
        .s_axis_dividend_tdata(s_dvd_dat), .s_axis_dividend_tvalid(s_dvd_vld),
        .s_axis_dividend_tready(s_dvd_rdy),
        .s_axis_divisor_tdata(s_dvs_dat), .s_axis_divisor_tvalid(s_dvs_vld),
        .s_axis_divisor_tready(s_dvs_rdy),
        .m_axis_dout_tdata(s_out_dat), .m_axis_dout_tvalid(s_out_vld)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input bit sg, input bit dv, input logic [31:0] dd,
                         input bit sv, input logic [31:0] sd);
        if (sg) begin
            s_dvd_vld = dv; s_dvd_dat = dd; s_dvs_vld = sv; s_dvs_dat = sd;
        end else begin
            u_dvd_vld = dv; u_dvd_dat = dd; u_dvs_vld = sv; u_dvs_dat = sd;
        end
    endtask

    // Offers dividend at once and divisor 'gap' cycles later; data is scrambled after each transfer.
    task automatic issue(input bit sg, input logic [31:0] a, input logic [31:0] b, input int gap,
                         input bit push, input logic [63:0] exp);
        bit   da = 0, db = 0, dv = 1, sv, dr, sr;
        int   n = 0, acc = 0;
        exp_t e;
        sv = (gap == 0);
        while (!(da && db) && n < 200) begin
            drive(sg, dv, da ? ~a : a, sv, db ? ~b : b);
            @(negedge clk);
            dr = sg ? s_dvd_rdy : u_dvd_rdy;
            sr = sg ? s_dvs_rdy : u_dvs_rdy;
            if (da && !db) check("dvd_rdy_after_accept", {63'd0, dr}, 64'd0);
            if (dv && dr) begin da = 1; dv = 0; acc = cyc; end
            if (sv && sr) begin db = 1; sv = 0; acc = cyc; end
            @(posedge clk); #1;
            n++;
            if (n >= gap && !db) sv = 1;
        end
        drive(sg, 1'b0, ~a, 1'b0, ~b);
        if (!(da && db)) begin
            checks++; errors++;
            $display("FAIL accept_timeout: operands %h/%h not accepted", a, b);
        end else if (push) begin
            e.d = exp;
            e.c = acc + 33;
            if (sg) sq.push_back(e); else uq.push_back(e);
        end
    endtask

    task automatic drain;
        int t = 0;
        while ((uq.size() != 0 || sq.size() != 0) && t < 500) begin
            @(posedge clk); t++;
        end
        #1;
        if (uq.size() != 0 || sq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d unsigned and %0d signed results missing", uq.size(), sq.size());
        end
    endtask

    always @(negedge clk) begin
        if (u_out_vld === 1'b1) begin
            if (uq.size() == 0) begin
                checks++; errors++;
                $display("FAIL u_spurious_vld: got tvalid at cycle %0d expected none", cyc);
            end else begin
                ue = uq.pop_front();
                check("u_dout", u_out_dat, ue.d);
                check("u_latency", 64'(cyc), 64'(ue.c));
                check("u_rdy_in_done", {62'd0, u_dvd_rdy, u_dvs_rdy}, 64'd0);
            end
        end
        if (s_out_vld === 1'b1) begin
            if (sq.size() == 0) begin
                checks++; errors++;
                $display("FAIL s_spurious_vld: got tvalid at cycle %0d expected none", cyc);
            end else begin
                se = sq.pop_front();
                check("s_dout", s_out_dat, se.d);
                check("s_latency", 64'(cyc), 64'(se.c));
                check("s_rdy_in_done", {62'd0, s_dvd_rdy, s_dvs_rdy}, 64'd0);
            end
        end
    end

    initial begin
        reset = 1'b1; u_cancel = 1'b0; s_cancel = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("u_reset_rdy",  {62'd0, u_dvd_rdy, u_dvs_rdy}, 64'd3);
        check("s_reset_rdy",  {62'd0, s_dvd_rdy, s_dvs_rdy}, 64'd3);
        check("u_reset_vld",  {63'd0, u_out_vld}, 64'd0);
        check("s_reset_vld",  {63'd0, s_out_vld}, 64'd0);
        check("u_reset_dat",  u_out_dat, 64'd0);
        check("s_reset_dat",  s_out_dat, 64'd0);
        @(posedge clk); #1;

        issue(1'b0, 32'd100,        32'd7,          0, 1'b1, {32'd14, 32'd2});
        issue(1'b0, 32'hFFFFFFFF,   32'd1,          0, 1'b1, {32'hFFFFFFFF, 32'd0});
        issue(1'b0, 32'd3,          32'hFFFFFFFF,   0, 1'b1, {32'd0, 32'd3});

        issue(1'b1, 32'hFFFFFFF9,   32'd2,          3, 1'b1, {32'hFFFFFFFD, 32'hFFFFFFFF});
        issue(1'b1, 32'h80000000,   32'hFFFFFFFF,   0, 1'b1, {32'h80000000, 32'd0});
        issue(1'b1, 32'd5,          32'd0,          0, 1'b1, {32'hFFFFFFFF, 32'd5});
        issue(1'b1, 32'hFFFFFFFB,   32'd0,          0, 1'b1, {32'h00000001, 32'hFFFFFFFB});

        // Cancel 10 cycles into CALC on the unsigned instance.
        issue(1'b0, 32'd100, 32'd7, 0, 1'b0, 64'd0);
        repeat (10) @(posedge clk);
        #1 u_cancel = 1'b1;
        @(posedge clk); #1 u_cancel = 1'b0;
        @(negedge clk);
        check("u_cancel_rdy", {62'd0, u_dvd_rdy, u_dvs_rdy}, 64'd3);
        check("u_cancel_hold_dat", u_out_dat, {32'd0, 32'd3});
        @(posedge clk); #1;
        issue(1'b0, 32'd9, 32'd3, 0, 1'b1, {32'd3, 32'd0});
        drain();

        // Reset in the middle of a signed CALC.
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 0, 1'b0, 64'd0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("s_midreset_vld", {63'd0, s_out_vld}, 64'd0);
        check("s_midreset_dat", s_out_dat, 64'd0);
        check("s_midreset_rdy", {62'd0, s_dvd_rdy, s_dvs_rdy}, 64'd3);
        repeat (40) @(posedge clk);
        #1;
        issue(1'b1, 32'd20,       32'hFFFFFFFD, 0, 1'b1, {32'hFFFFFFFA, 32'd2});
        issue(1'b1, 32'hFFFFFFEC, 32'd3,        0, 1'b1, {32'hFFFFFFFA, 32'hFFFFFFFE});
        drain();
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
